// File: rtl/mul_trunc_pipe.sv
// Column-truncated unsigned multiplier with run-time truncation column and a
// stallable, bubble-collapsing valid/ready pipeline of STAGES register slots.
module mul_trunc_pipe #(
    parameter int W      = 12,
    parameter int STAGES = 3,
    parameter int TW     = $clog2(2*W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic [TW-1:0]   in_trunc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_p,
    output logic [TW-1:0]   out_trunc,
    output logic            busy
);
    localparam int PW = 2*W;
    localparam logic [TW-1:0] T_MAX = TW'(PW-1);

    logic [TW-1:0] t_clamp;
    logic [PW-1:0] keep_mask;
    logic [PW-1:0] prod;

    // Each shifted row is masked to columns >= T before summing, so dropped
    // columns never generate carries while kept columns add exactly.
    always_comb begin
        t_clamp   = (in_trunc > T_MAX) ? T_MAX : in_trunc;
        keep_mask = ~((PW'(1) << t_clamp) - PW'(1));
        prod      = '0;
        for (int i = 0; i < W; i++) begin
            if (in_a[i])
                prod = prod + ((PW'(in_b) << i) & keep_mask);
        end
    end

    logic [STAGES-1:0]           vld_pipe;
    logic [STAGES-1:0]           ld;
    logic [STAGES-1:0][PW-1:0]   p_pipe;
    logic [STAGES-1:0][TW-1:0]   t_pipe;
    logic [STAGES-1:0]           src_v;
    logic [STAGES-1:0][PW-1:0]   src_p;
    logic [STAGES-1:0][TW-1:0]   src_t;

    // A slot loads when empty or when its successor is moving on; the chain
    // ends at out_ready, so in_ready never looks at in_valid.
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !vld_pipe[STAGES-1] || out_ready;
        for (int k = STAGES-2; k >= 0; k--)
            ld[k] = !vld_pipe[k] || ld[k+1];
    end

    always_comb begin
        src_v    = '0;
        src_p    = '0;
        src_t    = '0;
        src_v[0] = in_valid;
        src_p[0] = prod;
        src_t[0] = t_clamp;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = vld_pipe[k-1];
            src_p[k] = p_pipe[k-1];
            src_t[k] = t_pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            p_pipe   <= '0;
            t_pipe   <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld_pipe[k] <= src_v[k];
                    p_pipe[k]   <= src_p[k];
                    t_pipe[k]   <= src_t[k];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_pipe[STAGES-1];
    assign out_p     = p_pipe[STAGES-1];
    assign out_trunc = t_pipe[STAGES-1];
    assign busy      = |vld_pipe;

endmodule

// File: tb/tb_mul_trunc_pipe.sv
// Directed and streamed checks of mul_trunc_pipe (W=12, STAGES=3) against
// hand-computed values and an independent bit-pair reference model.
module tb_mul_trunc_pipe;
    localparam int W = 12;
    localparam int STAGES = 3;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [TW-1:0] in_trunc;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_p;
    logic [TW-1:0] out_trunc;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
        int             cyc;
    } exp_item_t;

    mul_trunc_pipe #(.W(W), .STAGES(STAGES), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_trunc(in_trunc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_trunc(out_trunc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Sum over every set bit pair at or above column t.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input int t);
        logic [63:0] s = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (a[i] && b[j] && (i + j) >= t)
                    s = s + (64'd1 << (i + j));
        return s[2*W-1:0];
    endfunction

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] t, input logic [2*W-1:0] wp,
                           input logic [TW-1:0] wt);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_trunc = t; out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_a = 12'hABC; in_b = 12'h123; in_trunc = 5'd0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_p"}, 64'(out_p), 64'(wp));
        chk({tag, "_t"}, 64'(out_trunc), 64'(wt));
    endtask

    task automatic run_stream(input string tag, input int n, input int vp, input int rp);
        exp_item_t q[$];
        exp_item_t e;
        int sent = 0;
        int cyc = 0;
        int budget = n * 20 + 200;
        int ti;
        while ((sent < n || q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            in_valid  = (sent < n) && ($urandom_range(99) < vp);
            in_a      = 12'($urandom);
            in_b      = 12'($urandom);
            in_trunc  = 5'($urandom);
            out_ready = ($urandom_range(99) < rp);
            #1;
            chk({tag, "_busy"}, 64'(busy), 64'(q.size() != 0));
            chk({tag, "_rdy"}, 64'(in_ready), 64'((q.size() < STAGES) || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk({tag, "_spurious"}, 64'(out_valid), 64'd0);
                end else begin
                    chk({tag, "_p"}, 64'(out_p), 64'(q[0].p));
                    chk({tag, "_t"}, 64'(out_trunc), 64'(q[0].t));
                    if (out_ready) begin
                        if (rp == 100)
                            chk({tag, "_lat"}, 64'(cyc - q[0].cyc), 64'(STAGES));
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                ti = int'(in_trunc);
                e.p = ref_mul(in_a, in_b, ti);
                e.t = (ti > 2*W-1) ? TW'(2*W-1) : in_trunc;
                e.cyc = cyc;
                q.push_back(e);
                sent++;
            end
            cyc++;
        end
        chk({tag, "_done"}, 64'((sent == n) && (q.size() == 0)), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bpa[5];
        logic [W-1:0] bpb[5];
        logic [2*W-1:0] bpp[5];
        int acc, got, stale;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_trunc = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_p", 64'(out_p), 64'd0);
        chk("rst_out_trunc", 64'(out_trunc), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        run_one("exact_ff",  12'hFFF, 12'hFFF, 5'd0,  24'hFFE001, 5'd0);
        run_one("trunc20",   12'hFFF, 12'hFFF, 5'd20, 24'hB00000, 5'd20);
        run_one("msb_t22",   12'h800, 12'h800, 5'd22, 24'h400000, 5'd22);
        run_one("msb_t23",   12'h800, 12'h800, 5'd23, 24'h000000, 5'd23);
        run_one("clamp31",   12'hFFF, 12'hFFF, 5'd31, 24'h000000, 5'd23);
        run_one("small_t0",  12'd3,   12'd5,   5'd0,  24'd15,     5'd0);
        run_one("small_t1",  12'd3,   12'd5,   5'd1,  24'd14,     5'd1);

        run_stream("stream", 100, 100, 100);

        // Backpressure: only STAGES accepted while stalled, then drain in order.
        bpa = '{12'd2, 12'd4, 12'd6, 12'd8, 12'd10};
        bpb = '{12'd3, 12'd5, 12'd7, 12'd9, 12'd11};
        bpp = '{24'd6, 24'd20, 24'd42, 24'd72, 24'd110};
        acc = 0; got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = (acc < 5);
            if (acc < 5) begin in_a = bpa[acc]; in_b = bpb[acc]; in_trunc = 5'd0; end
            #1;
            if (out_valid) chk("bp_hold", 64'(out_p), 64'(bpp[0]));
            if (in_valid && in_ready) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (acc < 5);
            if (acc < 5) begin in_a = bpa[acc]; in_b = bpb[acc]; end
            #1;
            if (out_valid && got < 5) begin
                chk("bp_p", 64'(out_p), 64'(bpp[got]));
                chk("bp_slot", 64'(c), 64'(got));
                got++;
            end
            if (in_valid && in_ready) acc++;
        end
        chk("bp_drained", 64'(got), 64'd5);
        @(negedge clk);
        in_valid = 1'b0;

        run_stream("rand", 10000, 50, 50);

        // Reset with a full pipeline, asserted between edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1;
            in_a = 12'(k + 100); in_b = 12'd77; in_trunc = 5'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_out_p", 64'(out_p), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (out_valid || busy) stale++;
        end
        chk("post_rst_stale", 64'(stale), 64'd0);
        run_one("post_rst", 12'd7, 12'd9, 5'd0, 24'd63, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
